assoc_cache_ctrl: RTL and testbench
===================================

Name: assoc_cache_ctrl

Overview:
Parametrised set-associative, write-through read cache between the memory-stage unit and the SRAM controller. It is the successor of the fixed 2-way/64-set controller and adds the following:
- configurable ways, sets and line words
- tree-PLRU replacement
- write-update on hit (the line is no longer invalidated)
- an explicit miss/write FSM
- a flush input
- saturating hit/miss counters

Parameters:
ADDR_W, 18, byte-address width of address and sram_address.
WORD_W, 32, data word width.
LINE_WORDS, 2, words per line; power of 2, ≥2; SRAM read width = LINE_WORDS*WORD_W.
SETS, 64, number of sets; power of 2.
WAYS, 2, associativity; one of 1, 2, 4.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
address  in  ADDR_W  byte address; held stable until ready
wdata  in  WORD_W  write data
MEM_R_EN  in  1  read request
MEM_W_EN  in  1  write request; wins if both requests are high
flush  in  1  one-cycle pulse; invalidate all lines
rdata  out  WORD_W  read data, valid when ready && MEM_R_EN
ready  out  1  request completes this cycle
sram_rdata  in  LINE_WORDS*WORD_W  full line from SRAM
sram_ready  in  1  SRAM operation done (one-cycle pulse)
sram_address  out  ADDR_W  SRAM address
sram_wdata  out  WORD_W  SRAM write data
sram_r_en  out  1  SRAM line read
sram_w_en  out  1  SRAM word write
hit_count  out  CNT_W  read hits, saturating
miss_count  out  CNT_W  read misses, saturating

Behaviour:
- Address split:
  - [1:0] is byte offset, ignored.
  - Next log2(LINE_WORDS) bits select the word.
  - Next log2(SETS) bits are the index.
  - Remaining upper bits are the tag.
- Storage per set and way: valid, tag, line. Per set: WAYS-1 PLRU bits.
- Hit: a valid way in the indexed set has a matching tag. At most one way can hit.
- Reset: valid, PLRU and counters = 0; FSM = IDLE.
  - Data/tag arrays are not reset.
  - ready=1 and sram_r_en=sram_w_en=0 in the cycle after rst while no request is pending.
- FSM states: IDLE, FILL, WRITE.
- IDLE with MEM_W_EN → WRITE; sram_w_en=1 combinationally in the same cycle.
- IDLE with MEM_R_EN:
  - Hit: ready=1 the same cycle (combinational) and rdata = the selected word of the hit way.
  - On that edge: PLRU marks the hit way most recently used, and hit_count increments.
- IDLE with MEM_R_EN and a miss → FILL; sram_r_en=1 the same cycle.
  - sram_address is line-aligned (word and byte bits zeroed).
- FILL:
  - sram_r_en stays 1 until sram_ready.
  - In the sram_ready cycle: ready=1 and rdata = selected word of sram_rdata.
  - On that edge: victim way = first invalid way (lowest index), otherwise the PLRU way. It gets line, tag and valid=1; it is marked MRU; miss_count increments. FSM → IDLE.
- WRITE:
  - sram_w_en=1, sram_address=address, sram_wdata=wdata until sram_ready.
  - In the sram_ready cycle: ready=1.
  - On that edge, if hit: the selected word of the hit way ← wdata, and the way is marked MRU. A miss does not allocate. FSM → IDLE.
- Outside WRITE, sram_wdata is 0 (no tri-state).
- No request: ready=1, sram_r_en=sram_w_en=0.
- Request removed mid-FILL/WRITE: illegal; behaviour is undefined but the FSM must still return to IDLE on sram_ready.
- flush:
  - In IDLE with no request: all valid bits clear on that edge.
  - Otherwise: latched, and applied on the edge the FSM returns to IDLE, after the fill/write update. A flush that coincides with a fill leaves the set invalid.
- Counters stick at all-ones.
- rst mid-FILL/WRITE: FSM → IDLE and valid bits clear; sram enables are 0 the next cycle.
- WAYS=1: no PLRU bits; the victim is always way 0.

Decomposition:
- Package cache_pkg:
  - localparams for offset, index and tag widths derived from the parameters
  - FSM state enum (IDLE, FILL, WRITE)
  - functions for PLRU victim selection and PLRU update
- Sub-module cache_set_array: tag/valid/data storage and hit compare per way. It outputs the hit vector and the per-way words.
- The top level holds the FSM, PLRU, counters and flush logic.

Test Plan:
- Read 0x00104 after reset → sram_r_en=1, sram_address=0x00100; sram_ready with line {0xBBBB0002,0xAAAA0001} → rdata=0xBBBB0002, miss_count=1. Reread 0x00100 → ready same cycle, rdata=0xAAAA0001, sram_r_en=0, hit_count=1.
- WAYS=2: fill tags A, B into set 0; read A; read miss C to set 0 → B is evicted; reread A hits; reread B misses.
- Write 0x12345678 to cached 0x00104 → sram_w_en held until sram_ready, ready=1. Next read 0x00104 hits with 0x12345678; no SRAM read.
- Write to uncached 0x20000 then read 0x20000 → miss (no allocate), miss_count increments.
- flush pulse during FILL → that fill's data is still returned; the reread misses. flush in IDLE → all previously cached addresses miss.
- rst asserted mid-FILL → next cycle sram_r_en=0, ready=1, counters=0; MEM_R_EN and MEM_W_EN both high → only WRITE is performed.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types, default geometry and tree-PLRU helpers for the set-associative read cache.
package cache_pkg;

    localparam int unsigned ByteOffW = 2;
    localparam int unsigned MaxWays  = 4;
    localparam int unsigned PlruW    = MaxWays - 1;

    localparam int unsigned DefAddrW     = 18;
    localparam int unsigned DefWordW     = 32;
    localparam int unsigned DefLineWords = 2;
    localparam int unsigned DefSets      = 64;
    localparam int unsigned DefWays      = 2;
    localparam int unsigned DefCntW      = 32;

    localparam int unsigned DefWordSelW = $clog2(DefLineWords);
    localparam int unsigned DefIndexW   = $clog2(DefSets);
    localparam int unsigned DefTagW     = DefAddrW - DefIndexW - DefWordSelW - ByteOffW;

    typedef enum logic [1:0] {StIdle, StFill, StWrite} state_e;

    typedef logic [PlruW-1:0] plru_t;

    // Bit 0 is the root; each bit points towards the less recently used half.
    function automatic logic [1:0] plru_victim(plru_t bits, int unsigned ways);
        logic [1:0] v;
        v = '0;
        if (ways == 2) begin
            v = {1'b0, bits[0]};
        end else if (ways == 4) begin
            v = bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
        end
        return v;
    endfunction

    function automatic plru_t plru_touch(plru_t bits, logic [1:0] way, int unsigned ways);
        plru_t b;
        b = bits;
        if (ways == 2) begin
            b[0] = ~way[0];
        end else if (ways == 4) begin
            b[0] = ~way[1];
            if (way[1]) b[2] = ~way[0];
            else        b[1] = ~way[0];
        end
        return b;
    endfunction

endpackage

// File: rtl/assoc_cache_ctrl_if.sv
// Request/response bus of the cache: memory-stage side and SRAM-controller side.
interface assoc_cache_ctrl_if #(
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned LINE_WORDS = 2
);
    logic [ADDR_W-1:0]            address;
    logic [WORD_W-1:0]            wdata;
    logic                         MEM_R_EN;
    logic                         MEM_W_EN;
    logic [WORD_W-1:0]            rdata;
    logic                         ready;
    logic [LINE_WORDS*WORD_W-1:0] sram_rdata;
    logic                         sram_ready;
    logic [ADDR_W-1:0]            sram_address;
    logic [WORD_W-1:0]            sram_wdata;
    logic                         sram_r_en;
    logic                         sram_w_en;

    modport slave (
        input  address, wdata, MEM_R_EN, MEM_W_EN, sram_rdata, sram_ready,
        output rdata, ready, sram_address, sram_wdata, sram_r_en, sram_w_en
    );

    modport master (
        output address, wdata, MEM_R_EN, MEM_W_EN, sram_rdata, sram_ready,
        input  rdata, ready, sram_address, sram_wdata, sram_r_en, sram_w_en
    );
endinterface

// File: rtl/cache_set_array.sv
// Valid/tag/data storage with per-way tag compare; valid bits reset, tags and data do not.
module cache_set_array
    import cache_pkg::*;
#(
    parameter int unsigned WAYS       = DefWays,
    parameter int unsigned SETS       = DefSets,
    parameter int unsigned LINE_WORDS = DefLineWords,
    parameter int unsigned WORD_W     = DefWordW,
    parameter int unsigned TAG_W      = DefTagW
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [$clog2(SETS)-1:0]             index,
    input  logic [TAG_W-1:0]                    tag,
    input  logic [$clog2(LINE_WORDS)-1:0]       word_sel,
    input  logic [WAYS-1:0]                     fill_oh,
    input  logic [LINE_WORDS*WORD_W-1:0]        fill_line,
    input  logic [WAYS-1:0]                     upd_oh,
    input  logic [WORD_W-1:0]                   upd_word,
    input  logic                                inval_all,
    output logic [WAYS-1:0]                     hit,
    output logic [WAYS-1:0]                     valid_set,
    output logic [WAYS-1:0][WORD_W-1:0]         way_word
);

    logic [WAYS-1:0]                    valid_q [SETS];
    logic [TAG_W-1:0]                   tag_q   [SETS][WAYS];
    logic [LINE_WORDS-1:0][WORD_W-1:0]  data_q  [SETS][WAYS];

    // Invalidation wins over a fill on the same edge.
    always_ff @(posedge clk) begin
        if (rst || inval_all) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
        end else begin
            for (int w = 0; w < WAYS; w++) begin
                if (fill_oh[w]) valid_q[index][w] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (fill_oh[w]) begin
                tag_q[index][w]  <= tag;
                data_q[index][w] <= fill_line;
            end else if (upd_oh[w]) begin
                data_q[index][w][word_sel] <= upd_word;
            end
        end
    end

    always_comb begin
        valid_set = valid_q[index];
        for (int w = 0; w < WAYS; w++) begin
            hit[w]      = valid_q[index][w] && (tag_q[index][w] == tag);
            way_word[w] = data_q[index][w][word_sel];
        end
    end

endmodule

// File: rtl/assoc_cache_ctrl.sv
// Write-through set-associative read cache: miss/write FSM, tree-PLRU, flush and hit/miss counters.
module assoc_cache_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W     = DefAddrW,
    parameter int unsigned WORD_W     = DefWordW,
    parameter int unsigned LINE_WORDS = DefLineWords,
    parameter int unsigned SETS       = DefSets,
    parameter int unsigned WAYS       = DefWays,
    parameter int unsigned CNT_W      = DefCntW
) (
    input  logic                 clk,
    input  logic                 rst,
    assoc_cache_ctrl_if.slave    bus,
    input  logic                 flush,
    output logic [CNT_W-1:0]     hit_count,
    output logic [CNT_W-1:0]     miss_count
);

    localparam int unsigned WSEL_W     = $clog2(LINE_WORDS);
    localparam int unsigned INDEX_W    = $clog2(SETS);
    localparam int unsigned TAG_W      = ADDR_W - INDEX_W - WSEL_W - ByteOffW;
    localparam int unsigned LINE_BYTES = LINE_WORDS * (WORD_W / 8);
    localparam logic [ADDR_W-1:0] LineMask = ~ADDR_W'(LINE_BYTES - 1);

    state_e state_q, state_d;
    logic   flush_pend_q, flush_pend_d;
    plru_t  plru_q [SETS];
    logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;

    logic [WSEL_W-1:0]  wsel;
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic [ADDR_W-1:0]  line_addr;
    logic               unused_boff;

    logic [WAYS-1:0]              hit, valid_set, fill_oh, upd_oh, victim_oh;
    logic [WAYS-1:0][WORD_W-1:0]  way_word;
    logic [WORD_W-1:0]            hit_word, sram_word;
    logic [LINE_WORDS-1:0][WORD_W-1:0] sram_line;
    logic [1:0] hit_idx, victim_idx, plru_way;
    logic       hit_any, fill_en, upd_en, plru_en, hit_inc, miss_inc, inval;

    assign wsel        = bus.address[ByteOffW +: WSEL_W];
    assign index       = bus.address[ByteOffW + WSEL_W +: INDEX_W];
    assign tag         = bus.address[ADDR_W-1 -: TAG_W];
    assign line_addr   = bus.address & LineMask;
    assign unused_boff = ^bus.address[ByteOffW-1:0];
    assign sram_line   = bus.sram_rdata;
    assign sram_word   = sram_line[wsel];
    assign hit_any     = |hit;
    assign fill_oh     = fill_en ? victim_oh : '0;
    assign upd_oh      = upd_en ? hit : '0;
    assign hit_count   = hit_cnt_q;
    assign miss_count  = miss_cnt_q;

    cache_set_array #(
        .WAYS       (WAYS),
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .WORD_W     (WORD_W),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .index     (index),
        .tag       (tag),
        .word_sel  (wsel),
        .fill_oh   (fill_oh),
        .fill_line (bus.sram_rdata),
        .upd_oh    (upd_oh),
        .upd_word  (bus.wdata),
        .inval_all (inval),
        .hit       (hit),
        .valid_set (valid_set),
        .way_word  (way_word)
    );

    // Lowest-index invalid way first, otherwise the PLRU choice.
    always_comb begin
        hit_idx  = '0;
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit[w]) begin
                hit_idx  = 2'(w);
                hit_word = hit_word | way_word[w];
            end
        end
        victim_idx = plru_victim(plru_q[index], WAYS);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_set[w]) victim_idx = 2'(w);
        end
        for (int w = 0; w < WAYS; w++) victim_oh[w] = (victim_idx == 2'(w));
    end

    always_comb begin
        state_d          = state_q;
        flush_pend_d     = flush_pend_q;
        bus.ready        = 1'b0;
        bus.rdata        = hit_word;
        bus.sram_r_en    = 1'b0;
        bus.sram_w_en    = 1'b0;
        bus.sram_address = line_addr;
        bus.sram_wdata   = '0;
        fill_en          = 1'b0;
        upd_en           = 1'b0;
        plru_en          = 1'b0;
        plru_way         = hit_idx;
        hit_inc          = 1'b0;
        miss_inc         = 1'b0;
        inval            = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.MEM_W_EN) begin
                    state_d          = StWrite;
                    bus.sram_w_en    = 1'b1;
                    bus.sram_address = bus.address;
                    bus.sram_wdata   = bus.wdata;
                    flush_pend_d     = flush;
                end else if (bus.MEM_R_EN) begin
                    if (hit_any) begin
                        bus.ready = 1'b1;
                        plru_en   = 1'b1;
                        hit_inc   = 1'b1;
                        inval     = flush;
                    end else begin
                        state_d       = StFill;
                        bus.sram_r_en = 1'b1;
                        flush_pend_d  = flush;
                    end
                end else begin
                    bus.ready = 1'b1;
                    inval     = flush;
                end
            end
            StFill: begin
                bus.sram_r_en = 1'b1;
                if (bus.sram_ready) begin
                    bus.ready    = 1'b1;
                    bus.rdata    = sram_word;
                    fill_en      = 1'b1;
                    plru_en      = 1'b1;
                    plru_way     = victim_idx;
                    miss_inc     = 1'b1;
                    inval        = flush_pend_q | flush;
                    flush_pend_d = 1'b0;
                    state_d      = StIdle;
                end else if (flush) begin
                    flush_pend_d = 1'b1;
                end
            end
            StWrite: begin
                bus.sram_w_en    = 1'b1;
                bus.sram_address = bus.address;
                bus.sram_wdata   = bus.wdata;
                if (bus.sram_ready) begin
                    bus.ready    = 1'b1;
                    upd_en       = hit_any;
                    plru_en      = hit_any;
                    inval        = flush_pend_q | flush;
                    flush_pend_d = 1'b0;
                    state_d      = StIdle;
                end else if (flush) begin
                    flush_pend_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            flush_pend_q <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            if (plru_en) plru_q[index] <= plru_touch(plru_q[index], plru_way, WAYS);
            if (hit_inc && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + 1'b1;
            if (miss_inc && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Directed table plus randomized traffic against a recency-list model of the cache and a word memory.
module tb_assoc_cache_ctrl;

    localparam int unsigned ADDR_W     = 18;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned LINE_WORDS = 2;
    localparam int unsigned SETS       = 64;
    localparam int unsigned WAYS       = 2;
    localparam int unsigned CNT_W      = 32;
    localparam int unsigned LINE_BYTES = LINE_WORDS * 4;
    localparam logic [LINE_WORDS*WORD_W-1:0] Junk = {LINE_WORDS{32'hDEAD_BEEF}};

    typedef struct {
        bit                idle;
        bit                wr;
        bit                both;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
        int                lat;
        int                flush_cyc;
        bit                exp_hit;
        logic [WORD_W-1:0] exp_rdata;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [CNT_W-1:0] hit_count, miss_count;

    int n_vec = 0;
    int n_bad = 0;

    logic [WORD_W-1:0] mem [logic [ADDR_W-1:0]];
    logic [ADDR_W-1:0] resident [$];
    logic [CNT_W-1:0]  hits_m, misses_m;
    vec_t              tbl [$];

    assoc_cache_ctrl_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS)) bus ();

    assoc_cache_ctrl #(
        .ADDR_W     (ADDR_W),
        .WORD_W     (WORD_W),
        .LINE_WORDS (LINE_WORDS),
        .SETS       (SETS),
        .WAYS       (WAYS),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .flush      (flush),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input int idx, input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL [%0d] %s: got 0x%0h, want 0x%0h", idx, name, got, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] line_of(logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(LINE_BYTES - 1);
    endfunction

    function automatic int unsigned set_of(logic [ADDR_W-1:0] a);
        return (32'(a) / LINE_BYTES) % SETS;
    endfunction

    function automatic logic [WORD_W-1:0] mem_rd(logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] w;
        w = a & ~ADDR_W'(3);
        if (mem.exists(w)) return mem[w];
        return 32'h5000_0000 | 32'(w);
    endfunction

    function automatic logic [LINE_WORDS*WORD_W-1:0] mem_line(logic [ADDR_W-1:0] a);
        logic [LINE_WORDS*WORD_W-1:0] l;
        for (int i = 0; i < LINE_WORDS; i++) l[i*WORD_W +: WORD_W] = mem_rd(line_of(a) + ADDR_W'(i * 4));
        return l;
    endfunction

    function automatic bit model_hit(logic [ADDR_W-1:0] a);
        foreach (resident[i]) if (resident[i] == line_of(a)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_touch(logic [ADDR_W-1:0] a);
        foreach (resident[i]) begin
            if (resident[i] == line_of(a)) begin
                resident.delete(i);
                break;
            end
        end
        resident.push_front(line_of(a));
    endfunction

    // Evict the least recently used resident line of the same set when the set is full.
    function automatic void model_alloc(logic [ADDR_W-1:0] a);
        int cnt = 0;
        int last = -1;
        foreach (resident[i]) begin
            if (set_of(resident[i]) == set_of(a)) begin
                cnt++;
                last = i;
            end
        end
        if (cnt >= int'(WAYS)) resident.delete(last);
        resident.push_front(line_of(a));
    endfunction

    function automatic vec_t mk_rd(logic [ADDR_W-1:0] a, int lat, int fc, bit h,
                                   logic [WORD_W-1:0] d);
        vec_t v;
        v.idle = 1'b0; v.wr = 1'b0; v.both = 1'b0; v.addr = a; v.wdata = '0;
        v.lat = lat; v.flush_cyc = fc; v.exp_hit = h; v.exp_rdata = d;
        return v;
    endfunction

    function automatic vec_t mk_wr(logic [ADDR_W-1:0] a, logic [WORD_W-1:0] d, int lat, int fc,
                                   bit both);
        vec_t v;
        v.idle = 1'b0; v.wr = 1'b1; v.both = both; v.addr = a; v.wdata = d;
        v.lat = lat; v.flush_cyc = fc; v.exp_hit = 1'b0; v.exp_rdata = '0;
        return v;
    endfunction

    function automatic vec_t mk_idle(bit fl);
        vec_t v;
        v.idle = 1'b1; v.wr = 1'b0; v.both = 1'b0; v.addr = '0; v.wdata = '0;
        v.lat = 0; v.flush_cyc = fl ? 0 : -1; v.exp_hit = 1'b0; v.exp_rdata = '0;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        @(posedge clk); #1;
        bus.address    = v.addr;
        bus.wdata      = v.wdata;
        bus.sram_ready = 1'b0;
        bus.sram_rdata = Junk;
        flush          = (v.flush_cyc == 0);
        if (v.idle) begin
            bus.MEM_R_EN = 1'b0;
            bus.MEM_W_EN = 1'b0;
            @(negedge clk);
            chk(idx, "idle_ready", 64'(bus.ready), 64'(1'b1));
            chk(idx, "idle_r_en", 64'(bus.sram_r_en), 64'(1'b0));
        end else begin
            bus.MEM_W_EN = v.wr;
            bus.MEM_R_EN = !v.wr || v.both;
            if (!v.wr && v.exp_hit) begin
                @(negedge clk);
                chk(idx, "hit_ready", 64'(bus.ready), 64'(1'b1));
                chk(idx, "hit_r_en", 64'(bus.sram_r_en), 64'(1'b0));
                chk(idx, "hit_rdata", 64'(bus.rdata), 64'(v.exp_rdata));
            end else begin
                for (int c = 0; c <= v.lat; c++) begin
                    if (c > 0) begin
                        @(posedge clk); #1;
                        flush          = (c == v.flush_cyc);
                        bus.sram_ready = (c == v.lat);
                        if (c == v.lat) bus.sram_rdata = mem_line(v.addr);
                    end
                    @(negedge clk);
                    chk(idx, "ready", 64'(bus.ready), 64'(c == v.lat));
                    if (v.wr) begin
                        chk(idx, "w_en", 64'(bus.sram_w_en), 64'(1'b1));
                        chk(idx, "w_r_en", 64'(bus.sram_r_en), 64'(1'b0));
                        chk(idx, "w_addr", 64'(bus.sram_address), 64'(v.addr));
                        if (c > 0) chk(idx, "w_wdata", 64'(bus.sram_wdata), 64'(v.wdata));
                    end else begin
                        chk(idx, "r_en", 64'(bus.sram_r_en), 64'(1'b1));
                        chk(idx, "r_w_en", 64'(bus.sram_w_en), 64'(1'b0));
                        chk(idx, "r_addr", 64'(bus.sram_address), 64'(line_of(v.addr)));
                        if (c == v.lat) chk(idx, "miss_rdata", 64'(bus.rdata), 64'(v.exp_rdata));
                    end
                end
            end
        end
        if (v.wr) begin
            mem[v.addr & ~ADDR_W'(3)] = v.wdata;
            if (model_hit(v.addr)) model_touch(v.addr);
        end else if (!v.idle) begin
            if (model_hit(v.addr)) begin
                if (hits_m != '1) hits_m++;
                model_touch(v.addr);
            end else begin
                if (misses_m != '1) misses_m++;
                model_alloc(v.addr);
            end
        end
        if (v.flush_cyc >= 0) resident.delete();
        @(posedge clk); #1;
        bus.MEM_R_EN   = 1'b0;
        bus.MEM_W_EN   = 1'b0;
        bus.sram_ready = 1'b0;
        flush          = 1'b0;
        @(negedge clk);
        chk(idx, "post_ready", 64'(bus.ready), 64'(1'b1));
        chk(idx, "post_w_en", 64'(bus.sram_w_en), 64'(1'b0));
        chk(idx, "hit_count", 64'(hit_count), 64'(hits_m));
        chk(idx, "miss_count", 64'(miss_count), 64'(misses_m));
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; flush = 1'b0;
        bus.address = '0; bus.wdata = '0; bus.MEM_R_EN = 1'b0; bus.MEM_W_EN = 1'b0;
        bus.sram_rdata = Junk; bus.sram_ready = 1'b0;
        hits_m = '0; misses_m = '0;
        mem[18'h00100] = 32'hAAAA_0001;
        mem[18'h00104] = 32'hBBBB_0002;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk(0, "rst_ready", 64'(bus.ready), 64'(1'b1));
        chk(0, "rst_r_en", 64'(bus.sram_r_en), 64'(1'b0));
        chk(0, "rst_w_en", 64'(bus.sram_w_en), 64'(1'b0));
        chk(0, "rst_hits", 64'(hit_count), 64'(0));
        chk(0, "rst_misses", 64'(miss_count), 64'(0));

        tbl.push_back(mk_rd(18'h00104, 2, -1, 1'b0, 32'hBBBB_0002));
        tbl.push_back(mk_rd(18'h00100, 1, -1, 1'b1, 32'hAAAA_0001));
        tbl.push_back(mk_wr(18'h00104, 32'h1234_5678, 3, -1, 1'b0));
        tbl.push_back(mk_rd(18'h00104, 1, -1, 1'b1, 32'h1234_5678));
        tbl.push_back(mk_wr(18'h20000, 32'hCAFE_F00D, 1, -1, 1'b0));
        tbl.push_back(mk_rd(18'h20000, 2, -1, 1'b0, 32'hCAFE_F00D));
        tbl.push_back(mk_rd(18'h00008, 1, -1, 1'b0, 32'h5000_0008));
        tbl.push_back(mk_rd(18'h00208, 2, -1, 1'b0, 32'h5000_0208));
        tbl.push_back(mk_rd(18'h00008, 1, -1, 1'b1, 32'h5000_0008));
        tbl.push_back(mk_rd(18'h00408, 1, -1, 1'b0, 32'h5000_0408));
        tbl.push_back(mk_rd(18'h00008, 1, -1, 1'b1, 32'h5000_0008));
        tbl.push_back(mk_rd(18'h00208, 1, -1, 1'b0, 32'h5000_0208));
        tbl.push_back(mk_rd(18'h00010, 3, 1, 1'b0, 32'h5000_0010));
        tbl.push_back(mk_rd(18'h00010, 2, -1, 1'b0, 32'h5000_0010));
        tbl.push_back(mk_rd(18'h00104, 1, -1, 1'b0, 32'h1234_5678));
        tbl.push_back(mk_rd(18'h00104, 1, -1, 1'b1, 32'h1234_5678));
        tbl.push_back(mk_idle(1'b1));
        tbl.push_back(mk_rd(18'h00104, 2, -1, 1'b0, 32'h1234_5678));
        tbl.push_back(mk_rd(18'h00010, 1, -1, 1'b0, 32'h5000_0010));
        for (int i = 0; i < tbl.size(); i++) run_vec(i + 1, tbl[i]);

        // Reset in the middle of a fill.
        @(posedge clk); #1;
        bus.address = 18'h00600; bus.MEM_R_EN = 1'b1;
        @(negedge clk);
        chk(100, "rstseq_r_en", 64'(bus.sram_r_en), 64'(1'b1));
        @(posedge clk); #1;
        @(negedge clk);
        chk(101, "rstseq_fill_r_en", 64'(bus.sram_r_en), 64'(1'b1));
        chk(101, "rstseq_fill_ready", 64'(bus.ready), 64'(1'b0));
        @(posedge clk); #1;
        rst = 1'b1; bus.MEM_R_EN = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk(102, "rstseq_r_en_after", 64'(bus.sram_r_en), 64'(1'b0));
        chk(102, "rstseq_w_en_after", 64'(bus.sram_w_en), 64'(1'b0));
        chk(102, "rstseq_ready", 64'(bus.ready), 64'(1'b1));
        chk(102, "rstseq_hits", 64'(hit_count), 64'(0));
        chk(102, "rstseq_misses", 64'(miss_count), 64'(0));
        resident.delete();
        hits_m = '0; misses_m = '0;
        run_vec(103, mk_rd(18'h00104, 1, -1, 1'b0, 32'h1234_5678));
        run_vec(104, mk_wr(18'h00608, 32'hABCD_0123, 2, -1, 1'b1));
        run_vec(105, mk_rd(18'h00608, 2, -1, 1'b0, 32'hABCD_0123));

        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            int lat;
            logic [ADDR_W-1:0] a;
            r   = $urandom_range(0, 99);
            lat = int'($urandom_range(1, 3));
            a   = ADDR_W'(($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 3)
                          | ($urandom_range(0, 1) << 2));
            if (r < 8) begin
                v = mk_idle($urandom_range(0, 3) == 0);
            end else if (r < 38) begin
                v = mk_wr(a, $urandom, lat,
                          ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 32'(lat))) : -1,
                          $urandom_range(0, 9) == 0);
            end else begin
                bit h;
                int fc;
                h  = model_hit(a);
                fc = -1;
                if ($urandom_range(0, 19) == 0) fc = h ? 0 : int'($urandom_range(0, 32'(lat)));
                v = mk_rd(a, lat, fc, h, mem_rd(a));
            end
            run_vec(1000 + i, v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
